// File: rtl/interp_mv_pkg.sv
// Shared constants, FSM state type and MV saturation helper for the
// fractional-refinement MV generator.
package interp_mv_pkg;

  localparam int unsigned MV_W = 19;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StIssue,
    StFin
  } mv_state_e;

  // Clamp a signed MV_W+1-bit sum into the signed MV_W range; never wraps.
  function automatic logic [MV_W-1:0] sat_mv(input logic [MV_W:0] sum);
    logic [MV_W-1:0] res;
    if (sum[MV_W] != sum[MV_W-1]) begin
      res = sum[MV_W] ? {1'b1, {(MV_W-1){1'b0}}} : {1'b0, {(MV_W-1){1'b1}}};
    end else begin
      res = sum[MV_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mv_offset_counter.sv
// Raster dx/dy offset counter over [-Range, +Range]^2 with grid index and last flag.
// With MV_GEN_SKIP_CENTER_EN defined, the (0,0) point is stepped over but still indexed.
module mv_offset_counter #(
  parameter int unsigned Range = 2,
  parameter int unsigned IdxW  = 5,
  parameter int unsigned OffW  = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_init,
  input  logic                   i_advance,
  output logic signed [OffW-1:0] o_dx,
  output logic signed [OffW-1:0] o_dy,
  output logic [IdxW-1:0]        o_idx,
  output logic                   o_last
);

  localparam logic signed [OffW-1:0] OffMax = OffW'(Range);
  localparam logic signed [OffW-1:0] OffMin = -OffMax;
  localparam logic signed [OffW-1:0] OffOne = OffW'(1);

  logic signed [OffW-1:0] r_dx;
  logic signed [OffW-1:0] r_dy;
  logic [IdxW-1:0]        r_idx;
  logic signed [OffW-1:0] w_step_dx;
  logic signed [OffW-1:0] w_step_dy;
  logic signed [OffW-1:0] w_next_dx;
  logic [IdxW-1:0]        w_idx_inc;
  logic                   w_row_end;
  logic                   w_skip;

  always_comb begin
    w_row_end = (r_dx == OffMax);
    w_step_dx = w_row_end ? OffMin : r_dx + OffOne;
    w_step_dy = w_row_end ? r_dy + OffOne : r_dy;
`ifdef MV_GEN_SKIP_CENTER_EN
    w_skip = (w_step_dx == '0) && (w_step_dy == '0);
`else
    w_skip = 1'b0;
`endif
    // The center never sits at a row end, so stepping over it is one more dx step.
    w_next_dx = w_skip ? w_step_dx + OffOne : w_step_dx;
    w_idx_inc = w_skip ? IdxW'(2) : IdxW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dx  <= '0;
      r_dy  <= '0;
      r_idx <= '0;
    end else if (i_init) begin
      r_dx  <= OffMin;
      r_dy  <= OffMin;
      r_idx <= '0;
    end else if (i_advance) begin
      r_dx  <= w_next_dx;
      r_dy  <= w_step_dy;
      r_idx <= r_idx + w_idx_inc;
    end
  end

  assign o_dx   = r_dx;
  assign o_dy   = r_dy;
  assign o_idx  = r_idx;
  assign o_last = (r_dx == OffMax) && (r_dy == OffMax);

endmodule

// File: rtl/mv_gen_ctrl.sv
// Candidate MV sequencer: walks the offset grid around a base MV and hands each
// candidate to the interpolator by valid/ready. MV_GEN_SKIP_CENTER_EN omits (0,0).
module mv_gen_ctrl
  import interp_mv_pkg::*;
#(
  parameter int unsigned Range = 2,
  parameter int unsigned IdxW  = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst_sync,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic signed [MV_W-1:0] i_base_mv_x,
  input  logic signed [MV_W-1:0] i_base_mv_y,
  input  logic                   i_mv_ready,
  output logic                   o_mv_x_we,
  output logic                   o_mv_y_we,
  output logic signed [MV_W-1:0] o_mv_x,
  output logic signed [MV_W-1:0] o_mv_y,
  output logic                   o_mv_valid,
  output logic [IdxW-1:0]        o_cand_idx,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned OffW = $clog2(Range + 1) + 1;

  mv_state_e              r_state;
  mv_state_e              w_state_d;
  logic [MV_W-1:0]        r_base_x;
  logic [MV_W-1:0]        r_base_y;
  logic signed [OffW-1:0] w_dx;
  logic signed [OffW-1:0] w_dy;
  logic                   w_last;
  logic                   w_init;
  logic                   w_advance;
  logic [MV_W:0]          w_sum_x;
  logic [MV_W:0]          w_sum_y;

  assign w_init    = (r_state == StIdle) && i_start && !i_abort;
  // An aborted handshake still completes on the bus but never moves the raster.
  assign w_advance = (r_state == StIssue) && i_mv_ready && !i_abort && !w_last;

  mv_offset_counter #(
    .Range (Range),
    .IdxW  (IdxW),
    .OffW  (OffW)
  ) u_offset_counter (
    .i_clk     (i_clk),
    .i_rst     (i_rst_sync),
    .i_init    (w_init),
    .i_advance (w_advance),
    .o_dx      (w_dx),
    .o_dy      (w_dy),
    .o_idx     (o_cand_idx),
    .o_last    (w_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst_sync) begin
      r_state  <= StIdle;
      r_base_x <= '0;
      r_base_y <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_init) begin
        r_base_x <= i_base_mv_x;
        r_base_y <= i_base_mv_y;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_init) w_state_d = StLoad;
      StLoad:  w_state_d = i_abort ? StIdle : StIssue;
      StIssue: begin
        if (i_abort) begin
          w_state_d = StIdle;
        end else if (i_mv_ready) begin
          w_state_d = w_last ? StFin : StLoad;
        end
      end
      StFin:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Sums are formed one bit wider so saturation can see the overflow.
  assign w_sum_x = {r_base_x[MV_W-1], r_base_x} + {{(MV_W+1-OffW){w_dx[OffW-1]}}, w_dx};
  assign w_sum_y = {r_base_y[MV_W-1], r_base_y} + {{(MV_W+1-OffW){w_dy[OffW-1]}}, w_dy};

  assign o_mv_x     = sat_mv(w_sum_x);
  assign o_mv_y     = sat_mv(w_sum_y);
  assign o_mv_x_we  = (r_state == StLoad);
  assign o_mv_y_we  = (r_state == StLoad);
  assign o_mv_valid = (r_state == StIssue);
  assign o_busy     = (r_state != StIdle);
  assign o_done     = (r_state == StFin);

endmodule

// File: tb/tb_mv_gen_ctrl.sv
// Randomized self-checking bench for mv_gen_ctrl against a grid-list reference model.
module tb_mv_gen_ctrl;
  import interp_mv_pkg::*;

  localparam int Range = 2;
  localparam int MaxMv = 2 ** (MV_W - 1) - 1;
  localparam int MinMv = -MaxMv - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic                   abort = 1'b0;
  logic                   ready = 1'b0;
  logic signed [MV_W-1:0] base_x = '0;
  logic signed [MV_W-1:0] base_y = '0;
  logic                   we_x;
  logic                   we_y;
  logic signed [MV_W-1:0] mv_x;
  logic signed [MV_W-1:0] mv_y;
  logic                   valid;
  logic [4:0]             idx;
  logic                   busy;
  logic                   done;

  int n_cmp = 0;
  int n_err = 0;
  int exp_x[$];
  int exp_y[$];
  int exp_i[$];

  always #5 clk = ~clk;

  mv_gen_ctrl #(
    .Range (Range),
    .IdxW  (5)
  ) dut (
    .i_clk       (clk),
    .i_rst_sync  (rst),
    .i_start     (start),
    .i_abort     (abort),
    .i_base_mv_x (base_x),
    .i_base_mv_y (base_y),
    .i_mv_ready  (ready),
    .o_mv_x_we   (we_x),
    .o_mv_y_we   (we_y),
    .o_mv_x      (mv_x),
    .o_mv_y      (mv_y),
    .o_mv_valid  (valid),
    .o_cand_idx  (idx),
    .o_busy      (busy),
    .o_done      (done)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int clamp(input int v);
    if (v > MaxMv) return MaxMv;
    if (v < MinMv) return MinMv;
    return v;
  endfunction

  function automatic logic signed [MV_W-1:0] rnd_mv();
    return MV_W'($urandom);
  endfunction

  // Reference: the ordered list of candidates a scan must issue.
  task automatic build_list(input int bx, input int by);
    exp_x.delete();
    exp_y.delete();
    exp_i.delete();
    for (int dy = -Range; dy <= Range; dy++) begin
      for (int dx = -Range; dx <= Range; dx++) begin
`ifdef MV_GEN_SKIP_CENTER_EN
        if (dx == 0 && dy == 0) continue;
`endif
        exp_x.push_back(clamp(bx + dx));
        exp_y.push_back(clamp(by + dy));
        exp_i.push_back((dy + Range) * (2 * Range + 1) + (dx + Range));
      end
    end
  endtask

  task automatic check_state(input string ph, input int k, input int e_we, input int e_valid,
                             input int e_busy, input int e_done);
    check_eq({ph, "_we_x"}, int'(we_x), e_we);
    check_eq({ph, "_we_y"}, int'(we_y), e_we);
    check_eq({ph, "_valid"}, int'(valid), e_valid);
    check_eq({ph, "_busy"}, int'(busy), e_busy);
    check_eq({ph, "_done"}, int'(done), e_done);
    if (k >= 0) begin
      check_eq($sformatf("%s_mv_x[%0d]", ph, k), int'(mv_x), exp_x[k]);
      check_eq($sformatf("%s_mv_y[%0d]", ph, k), int'(mv_y), exp_y[k]);
      check_eq($sformatf("%s_idx[%0d]", ph, k), int'(idx), exp_i[k]);
    end
  endtask

  // One scan; abort_k / rst_k >= 0 interrupt it at the first ISSUE cycle of that candidate.
  task automatic run_scan(input int bx, input int by, input int pct, input int stall_k,
                          input int stall_n, input int abort_k, input int rst_k);
    int n;
    int stalls;
    bit rdy;
    build_list(bx, by);
    n = exp_x.size();
    base_x = bx[MV_W-1:0];
    base_y = by[MV_W-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    base_x = rnd_mv();
    base_y = rnd_mv();
    for (int k = 0; k < n; k++) begin
      check_state("load", k, 1, 0, 1, 0);
      ready = 1'($urandom);
      tick();
      stalls = 0;
      for (int c = 0; c < 12; c++) begin
        check_state("issue", k, 0, 1, 1, 0);
        if (k == rst_k) begin
          start = 1'b1;
          ready = 1'b0;
          tick();
          start = 1'b0;
          check_state("ign_start", k, 0, 1, 1, 0);
          rst = 1'b1;
          start = 1'b1;
          abort = 1'b1;
          tick();
          rst = 1'b0;
          start = 1'b0;
          abort = 1'b0;
          check_state("rst_mid", -1, 0, 0, 0, 0);
          check_eq("rst_mv_x", int'(mv_x), 0);
          check_eq("rst_mv_y", int'(mv_y), 0);
          check_eq("rst_idx", int'(idx), 0);
          tick();
          check_state("post_rst", -1, 0, 0, 0, 0);
          return;
        end
        if (k == abort_k) begin
          abort = 1'b1;
          ready = 1'b1;
          tick();
          abort = 1'b0;
          ready = 1'b0;
          check_state("abort", -1, 0, 0, 0, 0);
          check_eq("abort_hold_x", int'(mv_x), exp_x[k]);
          check_eq("abort_hold_y", int'(mv_y), exp_y[k]);
          tick();
          check_state("post_abort", -1, 0, 0, 0, 0);
          return;
        end
        if (k == stall_k) rdy = (stalls >= stall_n);
        else rdy = (int'($urandom_range(99)) >= pct) || (stalls >= 3);
        ready = rdy;
        tick();
        ready = 1'b0;
        if (rdy) break;
        stalls++;
      end
    end
    check_state("fin", -1, 0, 0, 1, 1);
    tick();
    check_state("idle", -1, 0, 0, 0, 0);
  endtask

  initial begin
    tick();
    tick();
    check_state("reset", -1, 0, 0, 0, 0);
    check_eq("reset_mv_x", int'(mv_x), 0);
    check_eq("reset_mv_y", int'(mv_y), 0);
    check_eq("reset_idx", int'(idx), 0);
    rst = 1'b0;
    tick();

    // ABORT beats START in IDLE.
    start = 1'b1;
    abort = 1'b1;
    base_x = rnd_mv();
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_state("idle_abort", -1, 0, 0, 0, 0);
    tick();
    check_state("idle_abort2", -1, 0, 0, 0, 0);

    run_scan(100, -40, 0, -1, 0, -1, -1);
    run_scan(-5000, 1234, 0, 4, 3, -1, -1);
    run_scan(MaxMv, MinMv, 30, -1, 0, -1, -1);
    run_scan(MinMv + 1, MaxMv - 1, 30, -1, 0, -1, -1);
    run_scan(100, -40, 20, -1, 0, 7, -1);
    run_scan(100, -40, 20, -1, 0, -1, -1);
    run_scan(777, 888, 20, -1, 0, -1, 10);
    run_scan(0, 0, 0, -1, 0, -1, -1);
    for (int s = 0; s < 6; s++) begin
      run_scan(int'(rnd_mv()), int'(rnd_mv()), 25, -1, 0, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
